// File: rtl/llc_mem_responder.sv
// Next-level memory model below the LLC: queues line-fill/write-back requests, answers in order.
// Latency: first response beat LATENCY+1 cycles after a request becomes queue head.
// Backpressure: req_ready drops when the queue is full; response beats hold while rsp_ready is low.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_cmd 0=READ, 1=WRITE, 2/3 illegal; req_addr byte address
//   rsp_valid/rsp_ready   response handshake; rsp_data beat data, rsp_last final beat,
//                         rsp_write marks a write acknowledge
//   err_illegal           one-cycle pulse after an illegal command is accepted
// Optional: define LLC_MEM_STATS_EN to add stat_reads, stat_writes and stat_stall_cycles counters.

module llc_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 16,
  parameter int LATENCY = 8,
  parameter int QDEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_write,
  output logic              err_illegal
`ifdef LLC_MEM_STATS_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W    = $clog2(QDEPTH) + 1;
  localparam int LINE_W   = ADDR_W - 6;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int LAT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Request queue: only the line address and the read/write bit are kept.
  logic [LINE_W-1:0] q_line [QDEPTH];
  logic              q_wr   [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic [1:0]        state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [BEAT_W-1:0] beat_cnt;

  logic              accept;
  logic              push;
  logic              illegal_acc;
  logic              send;
  logic              head_wr;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] beat_addr;
  logic              last_beat;
  logic              pop;

  // The byte offset within the line never affects the response.
  logic unused_offset;
  assign unused_offset = ^req_addr[5:0];

  assign accept      = req_valid & req_ready;
  assign push        = accept & ~req_cmd[1];
  assign illegal_acc = accept & req_cmd[1];

  assign send      = (state == ST_SEND);
  assign head_wr   = q_wr[rd_ptr];
  assign line_base = {q_line[rd_ptr], 6'b0};
  assign beat_addr = line_base + (ADDR_W'(beat_cnt) << 2);
  assign last_beat = head_wr | (beat_cnt == BEAT_W'(BEATS - 1));
  assign pop       = send & rsp_ready & last_beat;

  // Outputs are decoded from registered state, so they are stable while stalled
  // and fall together with the asynchronous reset of the FSM.
  assign rsp_valid = send;
  assign rsp_write = send & head_wr;
  assign rsp_last  = send & last_beat;
  assign rsp_data  = (send & ~head_wr) ? DATA_W'(beat_addr) : '0;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Queue storage carries no reset; the occupancy count defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_line[wr_ptr] <= req_addr[ADDR_W-1:6];
      q_wr[wr_ptr]   <= req_cmd[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      req_ready   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      // Registered from next occupancy: a pop frees a slot only from the next cycle.
      req_ready   <= (count_nxt != CNT_W'(QDEPTH));
      err_illegal <= illegal_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            if (LATENCY == 0) begin
              state <= ST_SEND;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= LAT_W'(LAT_INIT);
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_SEND: begin
          if (rsp_ready) begin
            if (last_beat) begin
              // Returning through IDLE guarantees a gap between responses.
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LLC_MEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads        <= '0;
      stat_writes       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (pop && !head_wr) stat_reads  <= stat_reads + 1'b1;
      if (pop && head_wr)  stat_writes <= stat_writes + 1'b1;
      if (send && !rsp_ready) stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_mem_responder.sv
module tb_llc_mem_responder;

  localparam int LAT   = 8;
  localparam int QD    = 4;
  localparam int BEATS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_write;
  logic        err_illegal;
`ifdef LLC_MEM_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  llc_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .BEATS(BEATS), .LATENCY(LAT), .QDEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_write(rsp_write), .err_illegal(err_illegal)
`ifdef LLC_MEM_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Reference model: outstanding requests in issue order, the beat index of the
  // head response, and the edge at which the head entry became head.
  typedef struct {
    bit          wr;
    logic [31:0] base;
  } ent_t;

  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   head_since = 0;
  int   k = 0;
  int   rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random
  bit   exp_err = 1'b0;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check outputs against the model, drive rsp_ready,
  // update the model for the coming rising edge, then advance one cycle.
  task automatic step();
    bit   rr;
    bit   exp_vld;
    bit   exp_last;
    ent_t e;
    rr = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    rsp_ready = rr;
    last_acc = req_valid && req_ready;

    chk("req_ready", 32'(req_ready), 32'(mq.size() < QD));
    exp_vld = (mq.size() > 0) && (cyc - head_since >= LAT + 1);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (rsp_valid && mq.size() > 0) begin
      e = mq[0];
      exp_last = e.wr || (k == BEATS - 1);
      chk("rsp_data", rsp_data, e.wr ? 32'd0 : e.base + 32'(k) * 32'd4);
      chk("rsp_last", 32'(rsp_last), 32'(exp_last));
      chk("rsp_write", 32'(rsp_write), 32'(e.wr));
      if (rr) begin
        if (exp_last) begin
          void'(mq.pop_front());
          k = 0;
          head_since = cyc + 1;
        end else begin
          k++;
        end
      end
    end

    exp_err = 1'b0;
    if (last_acc) begin
      if (req_cmd[1]) begin
        exp_err = 1'b1;
      end else begin
        if (mq.size() == 0) head_since = cyc + 1;
        e.wr   = req_cmd[0];
        e.base = {req_addr[31:6], 6'b0};
        mq.push_back(e);
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("err_illegal", 32'(err_illegal), 32'(exp_err));
  endtask

  task automatic send_req(input logic [1:0] cmd, input logic [31:0] addr);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    for (int i = 0; i < 400; i++) begin
      step();
      if (last_acc) break;
    end
    chk("req_accept_timeout", 32'(last_acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && !rsp_valid) break;
      step();
    end
    chk("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_write", 32'(rsp_write), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    mq.delete();
    k = 0;
    exp_err = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    apply_reset();

    // Single READ, offset ignored, 16-beat fill after LAT+1 cycles
    rdy_mode = 1;
    send_req(2'd0, 32'h1000_0043);
    drain();

    // Single WRITE acknowledge
    send_req(2'd1, 32'h0000_0100);
    drain();

    // Fill the queue while stalled; an illegal command in between is not stored
    rdy_mode = 0;
    send_req(2'd0, 32'h2000_0000);
    send_req(2'd0, $urandom());
    send_req(2'd0, $urandom());
    send_req(2'd2, $urandom());
    idle(1);
    send_req(2'd0, $urandom());
    idle(3);
    // Fifth request waits for the first response to complete
    rdy_mode = 1;
    send_req(2'd1, $urandom());
    drain();

    // Random backpressure during bursts
    rdy_mode = 2;
    send_req(2'd0, $urandom());
    send_req(2'd1, $urandom());
    send_req(2'd0, $urandom());
    drain();

    // Random mix of commands, including illegal ones
    for (int n = 0; n < 20; n++) begin
      send_req(2'($urandom_range(0, 3)), $urandom());
      idle($urandom_range(0, 3));
    end
    drain();

    // Reset in the middle of a burst, then a fresh full READ
    rdy_mode = 1;
    send_req(2'd0, 32'h3000_0000);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid && k == 5) break;
      step();
    end
    chk("reached_beat5", 32'(k), 32'd5);
    apply_reset();
    send_req(2'd0, 32'h4000_0010);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/llc_mem_responder.md
Name: llc_mem_responder

Overview:
- Next-level memory model sitting below the LLC cache.
- Accepts line-fill (read) and write-back requests issued by the LLC on a miss or eviction.
- Queues them in order and, after a fixed access latency, returns either a line burst or a single write acknowledge over a valid/ready response channel.
- Read data is a deterministic address pattern, so the LLC bench can check fills without a backing store.

Parameters:
- ADDR_W, 32, request address width; line offset is addr[5:0], consistent with the 64-byte LLC line.
- DATA_W, 32, response beat width; only 32 is supported.
- BEATS, 16, beats per line burst (64 bytes / 4 bytes).
- LATENCY, 8, cycles from an entry reaching the queue head to its first response beat; 0 is legal.
- QDEPTH, 4, outstanding request queue depth; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept a request.
- req_cmd  in  2  0 = READ (line fill), 1 = WRITE (write-back); 2 and 3 are illegal.
- req_addr  in  ADDR_W  request byte address.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  LLC accepts the beat.
- rsp_data  out  DATA_W  beat data.
- rsp_last  out  1  final beat of the response.
- rsp_write  out  1  beat is a write acknowledge.
- err_illegal  out  1  one-cycle pulse when an illegal command is accepted.

Behaviour:
- Reset (async assert, sync deassert):
  - Queue emptied, FSM to IDLE, beat and latency counters cleared.
  - rsp_valid, rsp_data, rsp_last, rsp_write and err_illegal are all 0.
  - req_ready is 0 while rst is high, 1 from the first cycle after release.
- Accept rule: a request is accepted on a rising edge where req_valid and req_ready are both 1.
  - req_ready is 1 exactly when the queue is not full.
  - req_ready is registered off the occupancy count: no same-cycle pop-through.
  - A full queue with a simultaneous pop shows req_ready = 1 on the next cycle.
- Stored fields: addr[ADDR_W-1:6] and cmd. The offset is ignored and the line base is addr with [5:0] = 0.
- Illegal cmd (2, 3): accepted, not stored, err_illegal pulses high for one cycle the following cycle. The queue is unchanged.
- FSM states: IDLE, WAIT, SEND.
  - IDLE -> WAIT when the queue is non-empty. The latency counter loads LATENCY-1.
  - If LATENCY = 0, go IDLE -> SEND directly instead.
  - WAIT counts down by 1 per cycle and goes to SEND the cycle after the counter reads 0. The first beat appears exactly LATENCY+1 cycles after the entry becomes head.
  - In SEND, rsp_valid = 1.
    - READ: beat k (0..BEATS-1) has rsp_data = line_base + 4*k, rsp_write = 0, and rsp_last = 1 only on k = BEATS-1.
    - WRITE: a single beat with rsp_data = 0, rsp_write = 1, rsp_last = 1.
  - A beat advances only on rsp_valid & rsp_ready. While rsp_ready = 0, all rsp_* outputs hold stable.
  - On the last-beat handshake the head is popped and the FSM returns to IDLE. rsp_valid drops for at least one cycle between responses.
- Ordering: strict FIFO, and responses never interleave.
- Push and pop in the same cycle: both take effect and occupancy is unchanged.
- Pointers: wrap modulo QDEPTH. Occupancy counter is clog2(QDEPTH)+1 bits.
- Address arithmetic: line_base + 4*k is computed at ADDR_W bits. It cannot overflow because the offset is at most 60.
- Reset mid-burst: the burst is abandoned immediately and rsp_valid falls asynchronously. No partial completion after release.

Optional Feature:
- Macro: LLC_MEM_STATS_EN.
- When defined, three extra output ports exist, each a 32-bit counter with reset 0 that wraps at 2^32:
  - stat_reads: READ responses completed, counted on the last-beat handshake.
  - stat_writes: WRITE acknowledges completed.
  - stat_stall_cycles: cycles with rsp_valid & !rsp_ready.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset, then READ to addr 0x1000_0043 with rsp_ready = 1 and LATENCY = 8.
  - First beat appears 9 cycles after acceptance, with data 0x1000_0040.
  - 16 beats follow, incrementing by 4, the last being 0x1000_007C with rsp_last = 1.
- WRITE to 0x0000_0100 -> single beat: rsp_write = 1, rsp_last = 1, rsp_data = 0, after 9 cycles.
- Push 4 READs back-to-back with rsp_ready = 0.
  - req_ready = 0 after the 4th.
  - A 5th request is held until the first response completes.
  - Responses come out in issue order.
- Toggle rsp_ready randomly during a READ burst -> no beat lost or duplicated; data and last stay stable while stalled.
- req_cmd = 2 -> err_illegal pulses for exactly 1 cycle, no response, and the queue count is unchanged.
- Assert rst at beat 5 of a READ -> rsp_valid = 0 immediately, req_ready = 1 after release, and a new READ gets a full 16-beat response starting at beat 0.
